// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller: resolves memory waits, multi-cycle
// MDU occupancy, load-use hazards and taken-branch flushes into pipeline enables.
module hazard_stall_ctrl #(
    parameter int MDU_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegisterRt_i,
    input  logic [4:0]  IFID_RegisterRs_i,
    input  logic [4:0]  IFID_RegisterRt_i,
    input  logic        IDEX_MulDiv_i,
    input  logic        Branch_Taken_i,
    input  logic        Dmem_Req_i,
    input  logic        Dmem_Ack_i,
    output logic        PC_Write_o,
    output logic        IFID_Write_o,
    output logic        IFID_Flush_o,
    output logic        IDEX_Bubble_o,
    output logic        Pipe_Hold_o,
    output logic [1:0]  State_o,
    output logic [15:0] Stall_Count_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_BUSY = 2'b01,
        MEM_WAIT = 2'b10
    } stateT;

    localparam logic [3:0] MDU_RELOAD = 4'(MDU_CYCLES - 2);

    stateT       state;
    stateT       stateNext;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;
    logic [15:0] stallCount;

    logic evalCycle;
    logic ignoreMem;
    logic ignoreMdu;
    logic loadUse;
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
    logic pipeHold;

    assign loadUse = IDEX_MemRead_i && (IDEX_RegisterRt_i != 5'd0) &&
                     ((IDEX_RegisterRt_i == IFID_RegisterRs_i) ||
                      (IDEX_RegisterRt_i == IFID_RegisterRt_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Busy states either hold the pipe or fall through into a normal evaluation
    // with the condition that caused the wait masked off.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        evalCycle  = 1'b0;
        ignoreMem  = 1'b0;
        ignoreMdu  = 1'b0;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        pipeHold   = 1'b0;

        case (state)
            RUN: evalCycle = 1'b1;
            MDU_BUSY: begin
                if (cnt != 4'd0) begin
                    pipeHold = 1'b1;
                    cntNext  = cnt - 4'd1;
                end else begin
                    evalCycle = 1'b1;
                    ignoreMdu = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!Dmem_Ack_i) begin
                    pipeHold = 1'b1;
                end else begin
                    evalCycle = 1'b1;
                    ignoreMem = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase

        if (evalCycle) begin
            stateNext = RUN;
            if (Dmem_Req_i && !Dmem_Ack_i && !ignoreMem) begin
                pipeHold  = 1'b1;
                stateNext = MEM_WAIT;
            end else if (IDEX_MulDiv_i && !ignoreMdu) begin
                pipeHold  = 1'b1;
                stateNext = MDU_BUSY;
                cntNext   = MDU_RELOAD;
            end else if (loadUse) begin
                idexBubble = 1'b1;
            end else if (Branch_Taken_i) begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
                ifidFlush = 1'b1;
            end else begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
            end
        end

        if (rst_i) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b0;
            idexBubble = 1'b0;
            pipeHold   = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCount <= 16'd0;
        end else if (!pcWrite && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    assign PC_Write_o    = pcWrite;
    assign IFID_Write_o  = ifidWrite;
    assign IFID_Flush_o  = ifidFlush;
    assign IDEX_Bubble_o = idexBubble;
    assign Pipe_Hold_o   = pipeHold;
    assign State_o       = state;
    assign Stall_Count_o = stallCount;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-count based reference model.
module tb_hazard_stall_ctrl;

    localparam int MDU_CYCLES = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        IDEX_MemRead_i = 1'b0;
    logic [4:0]  IDEX_RegisterRt_i = 5'd0;
    logic [4:0]  IFID_RegisterRs_i = 5'd0;
    logic [4:0]  IFID_RegisterRt_i = 5'd0;
    logic        IDEX_MulDiv_i = 1'b0;
    logic        Branch_Taken_i = 1'b0;
    logic        Dmem_Req_i = 1'b0;
    logic        Dmem_Ack_i = 1'b0;
    logic        PC_Write_o;
    logic        IFID_Write_o;
    logic        IFID_Flush_o;
    logic        IDEX_Bubble_o;
    logic        Pipe_Hold_o;
    logic [1:0]  State_o;
    logic [15:0] Stall_Count_o;

    hazard_stall_ctrl #(.MDU_CYCLES(MDU_CYCLES)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i),
        .IDEX_RegisterRt_i(IDEX_RegisterRt_i),
        .IFID_RegisterRs_i(IFID_RegisterRs_i),
        .IFID_RegisterRt_i(IFID_RegisterRt_i),
        .IDEX_MulDiv_i(IDEX_MulDiv_i),
        .Branch_Taken_i(Branch_Taken_i),
        .Dmem_Req_i(Dmem_Req_i),
        .Dmem_Ack_i(Dmem_Ack_i),
        .PC_Write_o(PC_Write_o),
        .IFID_Write_o(IFID_Write_o),
        .IFID_Flush_o(IFID_Flush_o),
        .IDEX_Bubble_o(IDEX_Bubble_o),
        .Pipe_Hold_o(Pipe_Hold_o),
        .State_o(State_o),
        .Stall_Count_o(Stall_Count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        pc;
        logic        ifidW;
        logic        flush;
        logic        bubble;
        logic        hold;
        logic [1:0]  st;
        logic [15:0] stall;
    } expT;

    expT expQ[$];
    int  compared = 0;
    int  mismatched = 0;

    // Reference model: cycles the MDU op still has to spend in EX, whether a
    // memory access is outstanding, and the running stall total.
    int  mdlMduLeft = 0;
    bit  mdlMemWait = 0;
    int  mdlStalls = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic memRead, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt, input logic mulDiv,
                                 input logic br, input logic req, input logic ack);
        expT e;
        bit  fromMem;
        bit  fromMdu;
        @(negedge clk_i);
        rst_i             = rst;
        IDEX_MemRead_i    = memRead;
        IDEX_RegisterRt_i = exRt;
        IFID_RegisterRs_i = idRs;
        IFID_RegisterRt_i = idRt;
        IDEX_MulDiv_i     = mulDiv;
        Branch_Taken_i    = br;
        Dmem_Req_i        = req;
        Dmem_Ack_i        = ack;
        e = '0;
        if (rst) begin
            mdlMduLeft = 0;
            mdlMemWait = 0;
            mdlStalls  = 0;
        end else begin
            e.st    = (mdlMduLeft > 0) ? 2'b01 : (mdlMemWait ? 2'b10 : 2'b00);
            e.stall = 16'(mdlStalls);
            if (mdlMduLeft > 1) begin
                e.hold = 1'b1;
                mdlMduLeft--;
            end else if (mdlMemWait && !ack) begin
                e.hold = 1'b1;
            end else begin
                fromMem    = mdlMemWait;
                fromMdu    = (mdlMduLeft == 1);
                mdlMduLeft = 0;
                mdlMemWait = 0;
                if (req && !ack && !fromMem) begin
                    e.hold     = 1'b1;
                    mdlMemWait = 1;
                end else if (mulDiv && !fromMdu) begin
                    e.hold     = 1'b1;
                    mdlMduLeft = MDU_CYCLES - 1;
                end else if (memRead && exRt != 0 && (exRt == idRs || exRt == idRt)) begin
                    e.bubble = 1'b1;
                end else begin
                    e.pc    = 1'b1;
                    e.ifidW = 1'b1;
                    e.flush = br;
                end
            end
            if (!e.pc && mdlStalls < 65535) mdlStalls++;
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk_i);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("PC_Write", 16'(PC_Write_o), 16'(e.pc));
                checkOutput("IFID_Write", 16'(IFID_Write_o), 16'(e.ifidW));
                checkOutput("IFID_Flush", 16'(IFID_Flush_o), 16'(e.flush));
                checkOutput("IDEX_Bubble", 16'(IDEX_Bubble_o), 16'(e.bubble));
                checkOutput("Pipe_Hold", 16'(Pipe_Hold_o), 16'(e.hold));
                checkOutput("State", 16'(State_o), 16'(e.st));
                checkOutput("Stall_Count", Stall_Count_o, e.stall);
            end
        end
    end

    initial begin
        $display("[TB] start, MDU_CYCLES=%0d", MDU_CYCLES);
        applyStimulus(1, 1, 3, 3, 0, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use, then the same with register zero
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 9, 1, 9, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
        // MDU op held for its full residency
        for (int i = 0; i < MDU_CYCLES + 1; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        // memory wait, then release
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // everything at once: memory stall must win
        applyStimulus(0, 1, 7, 7, 0, 1, 1, 1, 0);
        applyStimulus(0, 1, 7, 7, 0, 1, 1, 1, 1);
        idle(MDU_CYCLES);
        // reset in the middle of an MDU op and of a memory wait
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 99) < 40),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 50));
        end
        idle(1);
        repeat (2) @(negedge clk_i);
        #4;
        checkOutput("queueDrain", 16'(expQ.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
